// File: rtl/instr_sram_fetch_if.sv
// SRAM read bus between the instruction fetcher
// and the board-level asynchronous SRAM.
interface instr_sram_fetch_if #(
  parameter int ADDR_BITS = 20
);
  logic [ADDR_BITS-1:0] sram_addr;
  logic [15:0]          sram_dq_in;
  logic                 sram_ce_n;
  logic                 sram_oe_n;
  logic                 sram_we_n;
  logic                 sram_ub_n;
  logic                 sram_lb_n;

  modport master (
    output sram_addr,
    output sram_ce_n,
    output sram_oe_n,
    output sram_we_n,
    output sram_ub_n,
    output sram_lb_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr,
    input  sram_ce_n,
    input  sram_oe_n,
    input  sram_we_n,
    input  sram_ub_n,
    input  sram_lb_n,
    output sram_dq_in
  );
endinterface

// File: rtl/instr_sram_fetch.sv
// PC-driven instruction fetcher: two 16-bit SRAM reads
// per word, with a one-entry last-word buffer.
module instr_sram_fetch #(
  parameter int          ADDR_BITS   = 20,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc_addr,
  input  logic                fetch_req,
  input  logic                invalidate,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic                stall,
  output logic                addr_err,
  instr_sram_fetch_if.master  sram
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t               state;
  state_t               state_d;
  logic [29:0]          p_reg;
  logic [15:0]          lo_reg;
  logic [3:0]           wcnt;
  logic [29:0]          buf_tag;
  logic                 buf_vld;
  logic                 half_q;
  logic [ADDR_BITS-2:0] a_reg;
  logic                 hit;
  logic                 bad;
  logic                 accept;
  logic                 lo_done;
  logic                 hi_done;
  logic                 ce_n;
  logic [ADDR_BITS-1:0] addr;

  assign a_reg = p_reg[ADDR_BITS-2:0];
  assign hit   = buf_vld &&
                 (pc_addr[31:2] == buf_tag);
  assign bad   = (pc_addr[1:0] != 2'b00) ||
                 (pc_addr[31:ADDR_BITS+1] != '0);

  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    lo_done     = 1'b0;
    hi_done     = 1'b0;
    ce_n        = 1'b1;
    addr        = {a_reg, half_q};
    unique case (state)
      IDLE: begin
        if (fetch_req && !hit) begin
          accept  = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        ce_n = 1'b0;
        addr = {a_reg, 1'b0};
        if (wcnt == 4'd0) begin
          lo_done = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        ce_n = 1'b0;
        addr = {a_reg, 1'b1};
        if (wcnt == 4'd0) begin
          hi_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    stall       = (state != IDLE) ||
                  (fetch_req && !hit);
    instr_valid = (state == IDLE) &&
                  fetch_req && hit;
    // Strobes drop in the very cycle reset is seen
    if (reset) begin
      state_d     = IDLE;
      accept      = 1'b0;
      lo_done     = 1'b0;
      hi_done     = 1'b0;
      ce_n        = 1'b1;
      addr        = '0;
      stall       = 1'b0;
      instr_valid = 1'b0;
    end
  end

  assign sram.sram_addr = addr;
  assign sram.sram_ce_n = ce_n;
  assign sram.sram_oe_n = ce_n;
  assign sram.sram_ub_n = ce_n;
  assign sram.sram_lb_n = ce_n;
  assign sram.sram_we_n = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      buf_vld  <= 1'b0;
      instr    <= RESET_INSTR;
      addr_err <= 1'b0;
      wcnt     <= 4'd0;
      p_reg    <= '0;
      half_q   <= 1'b0;
      lo_reg   <= '0;
      buf_tag  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        p_reg    <= pc_addr[31:2];
        wcnt     <= WS;
        addr_err <= addr_err | bad;
      end else if (lo_done) begin
        lo_reg <= sram.sram_dq_in;
        wcnt   <= WS;
      end else if (hi_done) begin
        instr   <= {sram.sram_dq_in, lo_reg};
        buf_tag <= p_reg;
        buf_vld <= 1'b1;
        half_q  <= 1'b1;
      end else if (state != IDLE) begin
        wcnt <= wcnt - 4'd1;
      end
      // A loader write beats a completing fill
      if (invalidate) begin
        buf_vld <= 1'b0;
      end
    end
  end

endmodule
